// File: rtl/i2c_bmp180_target_if.sv
`default_nettype none
// ============================================================================
// i2c_bmp180_target_if
// Two-wire bus bundle: SCL, the resolved SDA line level and the target's
// open-drain pull-down enable (SDA is only ever pulled to 0, never driven 1).
// Revision: 1.0
// ============================================================================
interface i2c_bmp180_target_if;
  logic scl;
  logic sda;
  logic sda_oe;

  modport master (output scl, input sda, input sda_oe);
  modport slave  (input scl, input sda, output sda_oe);
endinterface
`default_nettype wire

// File: rtl/i2c_bmp180_target.sv
`default_nettype none
// ============================================================================
// i2c_bmp180_target
// I2C target emulating the BMP180 register map, pointer auto-increment and
// the timed conversion cycle.
// Revision: 1.0
// ============================================================================
module i2c_bmp180_target #(
  parameter logic [6:0] ADDR        = 7'h77,
  parameter logic [7:0] CHIP_ID     = 8'h55,
  parameter int         CONV_CYCLES = 4500
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_bmp180_target_if.slave    bus,
  input  logic [15:0]           ut,
  input  logic [23:0]           up,
  input  logic [175:0]          calib,
  output logic [7:0]            ctrl,
  output logic                  busy,
  output logic [3:0]            state
);
  localparam int CNT_W = $clog2(CONV_CYCLES + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_REG       = 4'd3;
  localparam logic [3:0] S_REG_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RACK      = 4'd8;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  logic [2:0]       r_scl_sh, r_sda_sh;
  logic             r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;
  logic [3:0]       r_state;
  logic [3:0]       r_bitcnt;
  logic [6:0]       r_shift;
  logic [6:0]       r_tx;
  logic [7:0]       r_ptr;
  logic             r_rw;
  logic             r_oe;
  logic [7:0]       r_ctrl;
  logic [23:0]      r_out;
  logic [CNT_W-1:0] r_cnt;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last, w_wr;
  logic [7:0] w_byte, w_rd_byte;
  logic [10:0] w_cbit;

  // Two sync stages plus one history sample feed the majority vote.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_sh <= 3'b111;
      r_sda_sh <= 3'b111;
      r_scl_f  <= 1'b1;
      r_sda_f  <= 1'b1;
      r_scl_fd <= 1'b1;
      r_sda_fd <= 1'b1;
    end else begin
      r_scl_sh <= {r_scl_sh[1:0], bus.scl};
      r_sda_sh <= {r_sda_sh[1:0], bus.sda};
      r_scl_f  <= maj3(r_scl_sh);
      r_sda_f  <= maj3(r_sda_sh);
      r_scl_fd <= r_scl_f;
      r_sda_fd <= r_sda_f;
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_fd;
  assign w_scl_fall = ~r_scl_f & r_scl_fd;
  assign w_start    = r_scl_f & r_scl_fd & r_sda_fd & ~r_sda_f;
  assign w_stop     = r_scl_f & r_scl_fd & ~r_sda_fd & r_sda_f;
  assign w_byte     = {r_shift, r_sda_f};
  assign w_last     = (r_bitcnt == 4'd7);
  assign w_wr       = ~w_stop & ~w_start & w_scl_rise & w_last & (r_state == S_WDATA);
  assign w_cbit     = {8'hBF - r_ptr, 3'b000};

  always_comb begin
    w_rd_byte = 8'h00;
    if (r_ptr == 8'hD0)                          w_rd_byte = CHIP_ID;
    else if (r_ptr >= 8'hAA && r_ptr <= 8'hBF)   w_rd_byte = calib[w_cbit +: 8];
    else if (r_ptr == 8'hF4)                     w_rd_byte = r_ctrl;
    else if (r_ptr == 8'hF6)                     w_rd_byte = r_out[23:16];
    else if (r_ptr == 8'hF7)                     w_rd_byte = r_out[15:8];
    else if (r_ptr == 8'hF8)                     w_rd_byte = r_out[7:0];
  end

  // ACK states: first SCL fall pulls SDA, the rise marks the 9th clock,
  // the second fall leaves the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_bitcnt <= 4'd0;
      r_shift  <= 7'd0;
      r_tx     <= 7'd0;
      r_ptr    <= 8'h00;
      r_rw     <= 1'b0;
      r_oe     <= 1'b0;
    end else if (w_stop) begin
      r_state <= S_IDLE;
      r_oe    <= 1'b0;
    end else if (w_start) begin
      r_state  <= S_ADDR;
      r_bitcnt <= 4'd0;
      r_oe     <= 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_REG, S_WDATA: begin
          if (w_scl_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 4'd1;
            if (w_last) begin
              r_bitcnt <= 4'd0;
              case (r_state)
                S_ADDR: begin
                  if (w_byte[7:1] == ADDR) begin
                    r_state <= S_ADDR_ACK;
                    r_rw    <= w_byte[0];
                  end else begin
                    r_state <= S_IDLE;
                  end
                end
                S_REG: begin
                  r_ptr   <= w_byte;
                  r_state <= S_REG_ACK;
                end
                default: begin
                  r_ptr   <= r_ptr + 8'd1;
                  r_state <= S_WDATA_ACK;
                end
              endcase
            end
          end
        end
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
          if (w_scl_rise) begin
            r_bitcnt <= 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd0) begin
              r_oe <= 1'b1;
            end else begin
              r_bitcnt <= 4'd0;
              if (r_state == S_ADDR_ACK && r_rw) begin
                r_state <= S_RDATA;
                r_tx    <= w_rd_byte[6:0];
                r_oe    <= ~w_rd_byte[7];
              end else begin
                r_state <= (r_state == S_ADDR_ACK) ? S_REG : S_WDATA;
                r_oe    <= 1'b0;
              end
            end
          end
        end
        S_RDATA: begin
          if (w_scl_rise) begin
            r_bitcnt <= r_bitcnt + 4'd1;
            if (w_last) begin
              r_bitcnt <= 4'd0;
              r_state  <= S_RACK;
            end
          end else if (w_scl_fall) begin
            r_tx <= {r_tx[5:0], 1'b0};
            r_oe <= ~r_tx[6];
          end
        end
        S_RACK: begin
          if (w_scl_rise) begin
            if (r_sda_f) begin
              r_state <= S_IDLE;
            end else begin
              r_ptr    <= r_ptr + 8'd1;
              r_bitcnt <= 4'd1;
            end
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd0) begin
              r_oe <= 1'b0;
            end else begin
              r_bitcnt <= 4'd0;
              r_state  <= S_RDATA;
              r_tx     <= w_rd_byte[6:0];
              r_oe     <= ~w_rd_byte[7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A register write placed after the countdown wins, so a busy rewrite restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl <= 8'h00;
      r_out  <= 24'h000000;
      r_cnt  <= '0;
    end else begin
      if (r_ctrl[5]) begin
        if (r_cnt <= CNT_W'(1)) begin
          r_ctrl[5] <= 1'b0;
          r_cnt     <= '0;
          if (r_ctrl[4:0] == 5'h0E)      r_out <= {ut, 8'h00};
          else if (r_ctrl[4:0] == 5'h14) r_out <= up;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
      if (w_wr) begin
        if (r_ptr == 8'hF4) begin
          r_ctrl <= w_byte;
          if (w_byte[5]) r_cnt <= CNT_W'(CONV_CYCLES);
        end else if (r_ptr == 8'hE0 && w_byte == 8'hB6) begin
          r_ctrl <= 8'h00;
          r_out  <= 24'h000000;
          r_cnt  <= '0;
        end
      end
    end
  end

  assign bus.sda_oe = r_oe;
  assign ctrl       = r_ctrl;
  assign busy       = r_ctrl[5];
  assign state      = r_state;
endmodule
`default_nettype wire

// File: tb/tb_i2c_bmp180_target.sv
`default_nettype none
// ============================================================================
// tb_i2c_bmp180_target
// Bit-banged I2C master against a register-map reference model.
// Revision: 1.0
// ============================================================================
module tb_i2c_bmp180_target;
  localparam int CONV = 1500;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         m_low = 1'b0;
  logic [15:0]  ut;
  logic [23:0]  up;
  logic [175:0] calib;
  logic [7:0]   ctrl;
  logic         busy;
  logic [3:0]   state;

  int passed   = 0;
  int failed   = 0;
  int total    = 0;
  int busy_cnt = 0;

  logic [7:0] calib_b [22];
  logic [7:0] m_ptr, m_ctrl;
  logic [7:0] m_out [3];

  i2c_bmp180_target_if bus();
  assign bus.sda = ~(m_low | bus.sda_oe);

  i2c_bmp180_target #(.ADDR(7'h77), .CHIP_ID(8'h55), .CONV_CYCLES(CONV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ut    (ut),
    .up    (up),
    .calib (calib),
    .ctrl  (ctrl),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  initial begin
    #(900000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_read(input logic [7:0] p);
    int ip = int'(p);
    if (ip == 'hD0) return 8'h55;
    if (ip >= 'hAA && ip <= 'hBF) return calib_b[ip - 'hAA];
    if (ip == 'hF4) return m_ctrl;
    if (ip >= 'hF6 && ip <= 'hF8) return m_out[ip - 'hF6];
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_ptr = 8'h00; m_ctrl = 8'h00;
    for (int i = 0; i < 3; i++) m_out[i] = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    tick(3); m_low = 1'b0; tick(9); bus.scl = 1'b1; tick(12);
    m_low = 1'b1; tick(12); bus.scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(3); m_low = 1'b1; tick(9); bus.scl = 1'b1; tick(12);
    m_low = 1'b0; tick(12);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      tick(3); m_low = ~b[i]; tick(9); bus.scl = 1'b1; tick(12); bus.scl = 1'b0;
    end
    tick(3); m_low = 1'b0; tick(9); bus.scl = 1'b1; tick(6);
    ack = bus.sda; tick(6); bus.scl = 1'b0;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    tick(3); m_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(9); bus.scl = 1'b1; tick(6);
      b = {b[6:0], bus.sda}; tick(6); bus.scl = 1'b0; tick(3);
    end
    m_low = ~nack; tick(9); bus.scl = 1'b1; tick(12); bus.scl = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] r, input logic [7:0] d);
    logic a;
    i2c_start();
    send_byte(8'hEE, a); chk("wr addr ack", {31'd0, a}, 0);
    send_byte(r, a);     chk("wr reg ack", {31'd0, a}, 0);
    send_byte(d, a);     chk("wr data ack", {31'd0, a}, 0);
    i2c_stop();
    if (r == 8'hF4) m_ctrl = d;
    else if (r == 8'hE0 && d == 8'hB6) begin
      m_ctrl = 8'h00;
      for (int i = 0; i < 3; i++) m_out[i] = 8'h00;
    end
    m_ptr = r + 8'd1;
  endtask

  task automatic rd_regs(input logic [7:0] r, input int n, input string tag);
    logic a;
    logic [7:0] b;
    i2c_start();
    send_byte(8'hEE, a); chk({tag, " addr-w ack"}, {31'd0, a}, 0);
    send_byte(r, a);     chk({tag, " reg ack"}, {31'd0, a}, 0);
    i2c_start();
    send_byte(8'hEF, a); chk({tag, " addr-r ack"}, {31'd0, a}, 0);
    m_ptr = r;
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      chk($sformatf("%s[%0d]", tag, i), {24'd0, b}, {24'd0, ref_read(m_ptr)});
      if (i != n - 1) m_ptr = m_ptr + 8'd1;
    end
    i2c_stop();
    chk({tag, " sda released"}, {31'd0, bus.sda_oe}, 0);
  endtask

  // busy_cnt counts high cycles since c0; the completed conversion updates the model.
  task automatic wait_conv(input int c0, input string tag);
    for (int k = 0; k < 5 * CONV && busy; k++) tick(1);
    chk({tag, " busy fell"}, {31'd0, busy}, 0);
    tick(2);
    chk({tag, " busy width"}, busy_cnt - c0, CONV);
    if (m_ctrl[4:0] == 5'h0E) begin
      m_out[0] = ut[15:8]; m_out[1] = ut[7:0]; m_out[2] = 8'h00;
    end else if (m_ctrl[4:0] == 5'h14) begin
      m_out[0] = up[23:16]; m_out[1] = up[15:8]; m_out[2] = up[7:0];
    end
    m_ctrl[5] = 1'b0;
  endtask

  initial begin
    logic a;
    logic [7:0] v;
    int c0;

    for (int i = 0; i < 22; i++) begin
      calib_b[i] = 8'($urandom);
      calib[175 - 8 * i -: 8] = calib_b[i];
    end
    ut = 16'($urandom);
    up = 24'($urandom);
    model_reset();
    bus.scl = 1'b1;

    tick(5);
    chk("reset state", {28'd0, state}, 0);
    chk("reset ctrl", {24'd0, ctrl}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset sda", {31'd0, bus.sda}, 1);
    reset = 1'b1;
    tick(10);

    rd_regs(8'hD0, 1, "chip_id");
    rd_regs(8'hAA, 23, "calib");

    i2c_start();
    send_byte(8'hEC, a); chk("bad addr nack", {31'd0, a}, 1);
    chk("bad addr idle", {28'd0, state}, 0);
    for (int i = 0; i < 2; i++) begin
      send_byte(8'($urandom), a);
      chk("ignored byte nack", {31'd0, a}, 1);
      chk("ignored byte idle", {28'd0, state}, 0);
    end
    i2c_stop();
    rd_regs(8'hD0, 1, "id after bad addr");

    c0 = busy_cnt;
    wr_reg(8'hF4, 8'h2E);
    chk("temp busy", {31'd0, busy}, 1);
    rd_regs(8'hF4, 1, "poll busy");
    wait_conv(c0, "temp");
    rd_regs(8'hF4, 1, "poll done");
    rd_regs(8'hF6, 3, "ut");

    c0 = busy_cnt;
    wr_reg(8'hF4, 8'h34);
    wait_conv(c0, "press");
    rd_regs(8'hF6, 3, "up");
    v = 8'($urandom);
    if (v == 8'hB6) v = 8'h00;
    wr_reg(8'hE0, v);
    rd_regs(8'hF4, 1, "ctrl kept");
    wr_reg(8'hE0, 8'hB6);
    chk("soft reset ctrl", {24'd0, ctrl}, 0);
    rd_regs(8'hF6, 3, "out cleared");

    i2c_start();
    send_byte(8'hEE, a); chk("rst-seq addr ack", {31'd0, a}, 0);
    send_byte(8'hE0, a); chk("rst-seq reg ack", {31'd0, a}, 0);
    i2c_start();
    send_byte(8'hEF, a); chk("rst-seq read ack", {31'd0, a}, 0);
    tick(12);
    chk("target drives 0", {31'd0, bus.sda}, 0);
    reset = 1'b0;
    #1;
    chk("reset releases oe", {31'd0, bus.sda_oe}, 0);
    chk("reset sda high", {31'd0, bus.sda}, 1);
    chk("reset state idle", {28'd0, state}, 0);
    model_reset();
    tick(4);
    reset = 1'b1;
    tick(4);
    m_low   = 1'b0;
    bus.scl = 1'b1;
    tick(30);
    rd_regs(8'hD0, 1, "id after reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
